// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: owns the PC, the IF/ID and ID/EX control
// registers, a RUN/STALL/FLUSH state register, saturating hold/flush
// counters and a sticky watchdog that flags long uninterrupted holds.
module pipe_stall_ctrl #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCwrite,
  input  logic              IFIDwrite,
  input  logic              controlmux,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc4,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [1:0]        state,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
  output logic              deadlock
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);
  localparam logic [DATA_W-1:0] NOP     = '0;
  localparam logic [3:0]        WD_LAST = 4'd14;

  // Saturating 16-bit event counter step.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating 4-bit watchdog step.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] pc4_p0;
  logic [DATA_W-1:0] ifid_instr_p1;
  logic [DATA_W-1:0] ifid_pc4_p1;
  logic [CTRL_W-1:0] idex_ctrl_p2;
  state_t            state_q;
  state_t            state_d;
  logic [15:0]       stall_cnt_q;
  logic [15:0]       flush_cnt_q;
  logic [3:0]        wd_q;
  logic              deadlock_q;
  logic              hold;

  // A hold only counts when no taken branch overrides it.
  assign hold   = PCwrite && !branch_taken;
  assign pc4_p0 = pc_p0 + PC_STEP;

  // IF stage: fetch address, redirect wins over hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= '0;
    end else if (branch_taken) begin
      pc_p0 <= branch_target;
    end else if (!PCwrite) begin
      pc_p0 <= pc4_p0;
    end
  end

  // IF/ID boundary: flush to NOP on a taken branch, else load unless held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_p1 <= '0;
      ifid_pc4_p1   <= '0;
    end else if (branch_taken) begin
      ifid_instr_p1 <= NOP;
      ifid_pc4_p1   <= '0;
    end else if (!IFIDwrite) begin
      ifid_instr_p1 <= instr_in;
      ifid_pc4_p1   <= pc4_p0;
    end
  end

  // ID/EX boundary: insert a bubble on a hazard or a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_p2 <= '0;
    end else if (controlmux || branch_taken) begin
      idex_ctrl_p2 <= '0;
    end else begin
      idex_ctrl_p2 <= id_ctrl;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush beats stall beats run; FLUSH lasts one cycle.
  always_comb begin
    state_d = ST_RUN;
    if (branch_taken) begin
      state_d = ST_FLUSH;
    end else if (PCwrite) begin
      state_d = ST_STALL;
    end
  end

  // Saturating hold and taken-branch counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
      if (branch_taken) begin
        flush_cnt_q <= sat_inc16(flush_cnt_q);
      end
    end
  end

  // Watchdog: count consecutive holds; flag sticks once the 15th arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q       <= '0;
      deadlock_q <= 1'b0;
    end else begin
      wd_q <= hold ? sat_inc4(wd_q) : 4'd0;
      if (hold && (wd_q >= WD_LAST)) begin
        deadlock_q <= 1'b1;
      end
    end
  end

  assign pc         = pc_p0;
  assign ifid_instr = ifid_instr_p1;
  assign ifid_pc4   = ifid_pc4_p1;
  assign idex_ctrl  = idex_ctrl_p2;
  assign state      = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign deadlock   = deadlock_q;

endmodule
